// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: frame sequencer for a 32-point streaming FFT core.
// Latches direction/scaling config, issues the core start and config-write
// strobes, meters N input samples under an rfd-gated handshake and frames
// the core's result stream with index and last-bin markers.
// Optional watchdog: define FFT_CTRL_TIMEOUT_EN to build the WAIT/LOAD
// timeout counter and the sticky err_timeout flag.
module fft_frame_ctrl #(
  parameter int          N_LOG2    = 5,
  parameter logic [5:0]  SCALE_DEF = 6'b101010
`ifdef FFT_CTRL_TIMEOUT_EN
  ,
  parameter int          TIMEOUT   = 255
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic              cfg_inv,
  input  logic [5:0]        cfg_scale,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              core_ce,
  output logic              core_start,
  output logic              core_fwd_inv,
  output logic              core_fwd_inv_we,
  output logic [5:0]        core_scale_sch,
  output logic              core_scale_sch_we,
  output logic [N_LOG2-1:0] core_xn_index,
  input  logic              core_rfd,
  input  logic              core_dv,
  input  logic [N_LOG2-1:0] core_xk_index,
  output logic              out_valid,
  output logic [N_LOG2-1:0] out_index,
  output logic              out_last,
  output logic              busy,
  output logic              err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_LOAD,
    S_WAIT,
    S_UNLOAD
  } state_t;

  localparam logic [N_LOG2-1:0] LAST_IDX = '1;

  state_t state, state_d;
  logic   inv_q;
  logic [5:0] scale_q;
  logic   accept;
  logic   out_active;
  logic   wd_fire;

  assign in_ready   = (state == S_LOAD) && core_rfd;
  assign accept     = in_ready && in_valid;
  assign busy       = (state != S_IDLE);

  // Config strobes are a pure decode of the single CFG cycle, so they are
  // exactly one cycle wide and cannot repeat within a frame.
  assign core_start        = (state == S_CFG);
  assign core_fwd_inv_we   = (state == S_CFG);
  assign core_scale_sch_we = (state == S_CFG);
  assign core_fwd_inv      = !inv_q;
  assign core_scale_sch    = scale_q;

  // Result path is a zero-latency pass-through, qualified by state.
  assign out_active = (state == S_WAIT) || (state == S_UNLOAD);
  assign out_valid  = out_active && core_dv;
  assign out_index  = out_active ? core_xk_index : '0;
  assign out_last   = out_valid && (core_xk_index == LAST_IDX);

`ifdef FFT_CTRL_TIMEOUT_EN
  logic [7:0] wd_cnt;
  logic       wd_run;

  // Counts only while stuck: WAIT without dv, or LOAD with the core stalled.
  // Any other cycle clears it, which also clears it on entry to WAIT.
  assign wd_run  = ((state == S_WAIT) && !core_dv) || ((state == S_LOAD) && !core_rfd);
  assign wd_fire = wd_run && (wd_cnt == 8'(TIMEOUT - 1));

  // Watchdog counter and sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      wd_cnt <= wd_run ? wd_cnt + 8'd1 : 8'd0;
      if (wd_fire) err_timeout <= 1'b1;
    end
  end
`else
  assign wd_fire     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // State register, clock enable, latched config and input sample index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      core_ce       <= 1'b0;
      inv_q         <= 1'b0;
      scale_q       <= SCALE_DEF;
      core_xn_index <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples
      // pre-edge values regardless of statement order.
      state   <= state_d;
      core_ce <= 1'b1;
      if ((state == S_IDLE) && cfg_we) begin
        inv_q   <= cfg_inv;
        scale_q <= cfg_scale;
      end
      if ((state == S_CFG) || wd_fire)
        core_xn_index <= '0;
      else if (accept)
        core_xn_index <= core_xn_index + 1'b1;  // wraps to 0 after the last sample
    end
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch forms.
    state_d = state;
    unique case (state)
      S_IDLE:   if (in_valid) state_d = S_CFG;
      S_CFG:    state_d = S_LOAD;
      S_LOAD:   if (accept && (core_xn_index == LAST_IDX)) state_d = S_WAIT;
      S_WAIT:   if (out_last) state_d = S_IDLE;
                else if (core_dv) state_d = S_UNLOAD;
      S_UNLOAD: if (out_last) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (wd_fire) state_d = S_IDLE;
  end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl: directed bench for fft_frame_ctrl. Stimulus pushes the
// expected input-sample indices and result markers into queues; a monitor on
// the falling edge pops and compares on every accepted sample and every
// valid result.
module tb_fft_frame_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cfg_we = 1'b0;
  logic       cfg_inv = 1'b0;
  logic [5:0] cfg_scale = 6'b000000;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       core_ce, core_start, core_fwd_inv, core_fwd_inv_we;
  logic [5:0] core_scale_sch;
  logic       core_scale_sch_we;
  logic [4:0] core_xn_index;
  logic       core_rfd = 1'b1;
  logic       core_dv = 1'b0;
  logic [4:0] core_xk_index = 5'd0;
  logic       out_valid;
  logic [4:0] out_index;
  logic       out_last;
  logic       busy;
  logic       err_timeout;

  int total = 0;
  int bad   = 0;

  logic [4:0] exp_xn[$];
  logic [5:0] exp_out[$];  // {index, last}

  always #5 clk = ~clk;

  fft_frame_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .cfg_we            (cfg_we),
    .cfg_inv           (cfg_inv),
    .cfg_scale         (cfg_scale),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .core_ce           (core_ce),
    .core_start        (core_start),
    .core_fwd_inv      (core_fwd_inv),
    .core_fwd_inv_we   (core_fwd_inv_we),
    .core_scale_sch    (core_scale_sch),
    .core_scale_sch_we (core_scale_sch_we),
    .core_xn_index     (core_xn_index),
    .core_rfd          (core_rfd),
    .core_dv           (core_dv),
    .core_xk_index     (core_xk_index),
    .out_valid         (out_valid),
    .out_index         (out_index),
    .out_last          (out_last),
    .busy              (busy),
    .err_timeout       (err_timeout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every accepted sample index and every valid result.
  initial begin
    forever begin
      @(negedge clk);
      if (in_valid && in_ready) begin
        if (exp_xn.size() == 0) check("xn_unexpected_accept", 32'(core_xn_index), 32'hffff);
        else check("xn_index", 32'(core_xn_index), 32'(exp_xn.pop_front()));
      end
      if (out_valid) begin
        if (exp_out.size() == 0) check("out_unexpected", 32'({out_index, out_last}), 32'hffff);
        else check("out_idx_last", 32'({out_index, out_last}), 32'(exp_out.pop_front()));
      end
    end
  end

  // Raise in_valid in IDLE and check the single CFG cycle.
  task automatic start_frame(input logic we, input logic inv, input logic [5:0] sc,
                             input logic exp_fwd, input logic [5:0] exp_sc, input int n_push);
    for (int i = 0; i < n_push; i++) exp_xn.push_back(5'(i));
    cfg_we = we; cfg_inv = inv; cfg_scale = sc; in_valid = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 0);
    check("idle_no_start", 32'(core_start), 0);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    check("cfg_start", 32'(core_start), 1);
    check("cfg_fwd_we", 32'(core_fwd_inv_we), 1);
    check("cfg_sch_we", 32'(core_scale_sch_we), 1);
    check("cfg_fwd_inv", 32'(core_fwd_inv), 32'(exp_fwd));
    check("cfg_scale", 32'(core_scale_sch), 32'(exp_sc));
    @(posedge clk); #1;
    check("load_start_width", 32'(core_start), 0);
    check("load_first_ready", 32'(in_ready), 1);
  endtask

  // Feed samples; optional rfd stall or reset abort at a given accept count.
  task automatic run_load(input int stall_at, input int abort_at);
    int acc = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    while (acc < 32 && cyc < 300) begin
      if (acc == abort_at) begin
        reset = 1'b0; in_valid = 1'b0;
        #1;
        check("rst_core_ce", 32'(core_ce), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_xn", 32'(core_xn_index), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_start", 32'(core_start), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        @(posedge clk); @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_ce_back", 32'(core_ce), 1);
        check("rst_idle", 32'(busy), 0);
        return;
      end
      if (acc == stall_at && !stalled) begin
        stalled = 1'b1;
        core_rfd = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("stall_ready", 32'(in_ready), 0);
          check("stall_xn_hold", 32'(core_xn_index), 32'(stall_at));
          @(posedge clk); #1;
        end
        core_rfd = 1'b1;
      end
      // Config writes during LOAD must be ignored.
      cfg_we = (acc == 5); cfg_inv = 1'b1; cfg_scale = 6'b111111;
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      @(posedge clk); #1;
      cyc++;
    end
    cfg_we = 1'b0;
    in_valid = 1'b0;
    check("load_count", 32'(acc), 32);
    check("wait_busy", 32'(busy), 1);
    check("wait_xn_wrap", 32'(core_xn_index), 0);
    check("wait_in_ready", 32'(in_ready), 0);
  endtask

  // Drive 32 result bins with one idle gap, then check return to IDLE.
  task automatic unload();
    for (int i = 0; i < 32; i++) begin
      exp_out.push_back({5'(i), (i == 31)});
      core_dv = 1'b1; core_xk_index = 5'(i);
      @(posedge clk); #1;
      if (i == 15) begin
        core_dv = 1'b0;
        @(negedge clk);
        check("gap_out_valid", 32'(out_valid), 0);
        @(posedge clk); #1;
      end
    end
    core_dv = 1'b0;
    check("after_last_idle", 32'(busy), 0);
    // dv outside WAIT/UNLOAD must not leak to the output.
    core_dv = 1'b1; core_xk_index = 5'd31;
    @(negedge clk);
    check("idle_out_gated", 32'({out_valid, out_index, out_last}), 0);
    @(posedge clk); #1;
    core_dv = 1'b0; core_xk_index = 5'd0;
  endtask

  initial begin
    #1;
    check("reset_ce", 32'(core_ce), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_xn", 32'(core_xn_index), 0);
    check("reset_strobes", 32'({core_start, core_fwd_inv_we, core_scale_sch_we}), 0);
    check("reset_out", 32'({out_valid, out_index, out_last}), 0);
    check("reset_err", 32'(err_timeout), 0);
    #11 reset = 1'b1;
    @(posedge clk); #1;
    check("ce_after_reset", 32'(core_ce), 1);

    // Basic FFT frame with default config.
    start_frame(1'b0, 1'b0, 6'b000000, 1'b1, 6'b101010, 32);
    run_load(-1, -1);
    unload();

    // IFFT config written in the same cycle as in_valid.
    start_frame(1'b1, 1'b1, 6'b010101, 1'b0, 6'b010101, 32);
    run_load(-1, -1);
    unload();

    // rfd stall at index 10; config must survive the LOAD-time cfg_we.
    start_frame(1'b0, 1'b0, 6'b000000, 1'b0, 6'b010101, 32);
    run_load(10, -1);
    unload();
    check("no_err_after_stall", 32'(err_timeout), 0);

    // Reset at index 17; config returns to its reset value.
    start_frame(1'b0, 1'b0, 6'b000000, 1'b0, 6'b010101, 17);
    run_load(-1, 17);
    check("abort_queue_drained", 32'(exp_xn.size()), 0);

    // Watchdog: core_dv never arrives.
    start_frame(1'b0, 1'b0, 6'b000000, 1'b1, 6'b101010, 32);
    run_load(-1, -1);
    repeat (254) @(posedge clk);
    #1;
    check("wd_err_early", 32'(err_timeout), 0);
    check("wd_busy_early", 32'(busy), 1);
    @(posedge clk); #1;
`ifdef FFT_CTRL_TIMEOUT_EN
    check("wd_err_set", 32'(err_timeout), 1);
    check("wd_idle", 32'(busy), 0);
`else
    check("wd_err_tied", 32'(err_timeout), 0);
    check("wd_busy_held", 32'(busy), 1);
    unload();
`endif

    check("xn_queue_empty", 32'(exp_xn.size()), 0);
    check("out_queue_empty", 32'(exp_out.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/fft_frame_ctrl.md
# fft_frame_ctrl

Frame sequencer for the 32-point, 16-bit streaming FFT core. It latches the per-frame direction and scaling configuration and issues the core's start, configuration-write and clock-enable controls. It meters 32 input samples into the core under an rfd-gated valid/ready handshake while generating `xn_index`, and re-times the core's result stream into a framed output with index and last-sample markers. It sits between the sample source and the FFT core instance.

## Interface
- `N_LOG2`, 5, log2 of the frame length; the frame is 32 points.
- `SCALE_DEF`, 6'b101010, scaling schedule loaded at reset.
- `TIMEOUT`, 255, cycles allowed in WAIT without `core_dv` (only with the macro).

Ports:
- `clk`  in  1  single clock; all logic rises on it.
- `reset`  in  1  asynchronous, active-low reset.
- `cfg_we`  in  1  latch `cfg_inv`/`cfg_scale`; honoured only in IDLE, ignored otherwise.
- `cfg_inv`  in  1  1 = IFFT, 0 = FFT; reset value 0 (FFT).
- `cfg_scale`  in  6  scaling schedule.
- `in_valid`  in  1  source sample valid.
- `in_ready`  out  1  sample accepted when `in_valid & in_ready`.
- `core_ce`  out  1  core clock enable.
- `core_start`  out  1  one-cycle frame start.
- `core_fwd_inv`  out  1  direction to core: 1 = FFT, 0 = IFFT, i.e. `!cfg_inv`.
- `core_fwd_inv_we`  out  1  direction write strobe.
- `core_scale_sch`  out  6  scaling schedule to core.
- `core_scale_sch_we`  out  1  scaling write strobe.
- `core_xn_index`  out  5  input sample index.
- `core_rfd`  in  1  core ready-for-data.
- `core_dv`  in  1  core output data valid.
- `core_xk_index`  in  5  core output index.
- `out_valid`  out  1  result valid.
- `out_index`  out  5  result bin index.
- `out_last`  out  1  bin 31 of the frame.
- `busy`  out  1  state != IDLE.
- `err_timeout`  out  1  sticky watchdog flag.

## Operation
- **States:** IDLE, CFG, LOAD, WAIT, UNLOAD. The state is encoded in registers.
- **Reset values:**
  - state = IDLE.
  - `core_ce` = 0; it goes to 1 on the first clock after reset deasserts and stays 1.
  - All strobes = 0; `core_xn_index` = 0.
  - Config = {inv 0, scale `SCALE_DEF`}.
  - `out_*` = 0; `busy` = 0; `err_timeout` = 0.
- **IDLE:**
  - `cfg_we` latches the configuration.
  - `in_valid` = 1 moves to CFG. The sample is not consumed; `in_ready` = 0 in IDLE.
  - If `cfg_we` and `in_valid` arrive in the same cycle, the new configuration applies to this frame.
- **CFG (exactly 1 cycle):**
  - `core_start`, `core_fwd_inv_we` and `core_scale_sch_we` are all high.
  - `core_fwd_inv` and `core_scale_sch` carry the latched configuration.
  - Next state is LOAD.
- **LOAD:**
  - `in_ready` = `core_rfd` (combinational).
  - Each accepted sample increments `core_xn_index`, modulo 32.
  - When the sample with index 31 is accepted, `core_xn_index` wraps to 0 and the state moves to WAIT.
  - If `core_rfd` drops, acceptance pauses; the index holds and no sample is lost.
- **WAIT:** `core_dv` = 1 moves to UNLOAD in the same cycle. That first bin is forwarded, because the output path is combinational from the core.
- **UNLOAD:**
  - `out_valid` = `core_dv`.
  - `out_index` = `core_xk_index`.
  - `out_last` = `core_dv & (core_xk_index == 31)`.
  - When `out_last` is 1, the next state is IDLE.
- **Output qualification:** `out_*` are forced to 0 outside WAIT and UNLOAD.
- **Reset mid-frame:** all state clears asynchronously and no partial frame is resumed. The next frame restarts from CFG.

## Timing
- **Frame-start latency:** `in_valid` rising in IDLE gives `core_start` on the following cycle. The first sample is accepted 2 cycles after `in_valid`, if `core_rfd` = 1.
- **Load time:** minimum 32 cycles in LOAD when `in_valid` and `core_rfd` are held high.
- **Output path:** zero-latency pass-through of `core_dv` and `core_xk_index`.
- **Back-to-back frames:** IDLE follows the `out_last` cycle. The next CFG cannot occur earlier than 1 cycle after `out_last`.
- **Strobe widths:** every strobe is exactly 1 cycle wide and never repeats within a frame.

## Configuration
- **`FFT_CTRL_TIMEOUT_EN` defined:**
  - An 8-bit counter runs in WAIT and clears on entering WAIT.
  - When it reaches `TIMEOUT` without `core_dv`, `err_timeout` sets (sticky until reset) and the state returns to IDLE.
  - The same counter also runs in LOAD while `core_rfd` = 0, with the same outcome.
- **Not defined:** no counter is built, `err_timeout` is tied to 0, and WAIT waits indefinitely.

## Test plan
- **Basic FFT frame:** reset, then `in_valid` = 1 with `core_rfd` = 1 and samples 0..31.
  - Expect `core_start` 1 cycle after `in_valid`.
  - Expect `core_fwd_inv` = 1, `core_scale_sch` = 6'b101010.
  - Expect `core_xn_index` to step 0..31 and then wrap to 0.
  - Then drive `core_dv` with indexes 0..31: `out_last` must be high only at index 31, followed by IDLE.
- **IFFT configuration:** `cfg_we` = 1, `cfg_inv` = 1, `cfg_scale` = 6'b010101 in IDLE, in the same cycle as `in_valid`.
  - The CFG cycle must show `core_fwd_inv` = 0 and scale 6'b010101.
  - `cfg_we` asserted during LOAD must leave the configuration unchanged.
- **rfd stall:** drop `core_rfd` for 5 cycles at index 10. Expect `in_ready` = 0, the index held at 10, and exactly 32 samples accepted in total.
- **Reset mid-LOAD:** assert `reset` = 0 at index 17.
  - All outputs must go to their reset values immediately, and `core_ce` = 0.
  - The next frame must start with `core_start` and index 0.
- **Watchdog, macro defined:** `core_dv` never asserted after LOAD. Expect `err_timeout` = 1 exactly 255 cycles after entering WAIT, then state IDLE with `busy` = 0.
- **Watchdog, macro undefined:** the same stimulus gives `err_timeout` = 0 and `busy` held at 1.
